// File: rtl/load_pkg.sv
// Shared definitions for the load datapath: funct3 codes, FSM encoding and
// the access-size decode used by both the aligner and the lane extractor.
package load_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } load_state_t;

    // Access size in bytes: 1, 2, 4 or 8.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

endpackage

// File: rtl/load_lane_extract.sv
// Combinational byte-lane extraction: shifts a two-beat window down to the
// addressed byte and sign- or zero-extends the selected width to XLEN.
module load_lane_extract
    import load_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OW   = 2
) (
    input  logic [2*XLEN-1:0] window,
    input  logic [OW-1:0]     off,
    input  logic [2:0]        funct3,
    output logic [XLEN-1:0]   result
);

    logic [XLEN-1:0] shifted;
    logic            ext_bit;
    int              nbits;

    // Align the addressed byte to lane 0, then overwrite bits above the access width.
    always_comb begin
        shifted = XLEN'(window >> {off, 3'b000});
        nbits   = 8 * int'(size_bytes(funct3));
        case (funct3[1:0])
            2'd0:    ext_bit = shifted[7];
            2'd1:    ext_bit = shifted[15];
            2'd2:    ext_bit = shifted[31];
            default: ext_bit = shifted[XLEN-1];
        endcase
        if (funct3[2]) begin
            ext_bit = 1'b0;
        end
        result = shifted;
        // Full-width accesses (LW on 32-bit, LD) leave every bit untouched.
        for (int i = 0; i < XLEN; i++) begin
            if (i >= nbits) begin
                result[i] = ext_bit;
            end
        end
    end

endmodule

// File: rtl/load_align_unit.sv
// Multi-cycle load aligner between the memory stage and a beat-wide data port.
// Boundary-crossing loads are split into two aligned beats when allowed.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ready for a request; illegal/misaligned requests go to RESP
//   ST_BEAT0 | first aligned beat outstanding on the memory port
//   ST_BEAT1 | second beat (next aligned address) of a crossing load
//   ST_RESP  | one-cycle result strobe, then back to IDLE
module load_align_unit
    import load_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int AW               = 32,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_addr,
    input  logic [2:0]      req_funct3,
    output logic            mem_req,
    output logic [AW-1:0]   mem_addr,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    load_state_t     state;
    logic [OW-1:0]   off_q;
    logic [2:0]      f3_q;
    logic            cross_q;
    logic [XLEN-1:0] beat0_q;

    logic [OW-1:0]     req_off;
    logic [4:0]        req_end;
    logic              req_cross;
    logic              req_illegal;
    logic              req_bad;
    logic [2*XLEN-1:0] window;
    logic [XLEN-1:0]   lane_result;

    // Request decode; a crossing load is rejected only when splitting is disabled.
    always_comb begin
        req_off     = req_addr[OW-1:0];
        req_end     = 5'(req_off) + 5'(size_bytes(req_funct3));
        req_cross   = (req_end > 5'(NB));
        req_illegal = (req_funct3 == 3'b111) ||
                      ((XLEN == 32) && ((req_funct3 == F3_LD) || (req_funct3 == F3_LWU)));
        req_bad     = req_illegal || (req_cross && (ALLOW_MISALIGNED == 0));
    end

    // Window seen by the extractor on the cycle the final beat arrives.
    always_comb begin
        window = {{XLEN{1'b0}}, mem_rdata};
        if (state == ST_BEAT1) begin
            window = {mem_rdata, beat0_q};
        end
    end

    load_lane_extract #(
        .XLEN (XLEN),
        .OW   (OW)
    ) u_extract (
        .window (window),
        .off    (off_q),
        .funct3 (f3_q),
        .result (lane_result)
    );

    // Sequencing FSM with registered handshake, address and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            off_q     <= '0;
            f3_q      <= '0;
            cross_q   <= 1'b0;
            beat0_q   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (req_bad) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            state     <= ST_RESP;
                        end else begin
                            off_q    <= req_off;
                            f3_q     <= req_funct3;
                            cross_q  <= req_cross;
                            mem_addr <= {req_addr[AW-1:OW], {OW{1'b0}}};
                            mem_req  <= 1'b1;
                            state    <= ST_BEAT0;
                        end
                    end
                end
                ST_BEAT0: begin
                    if (mem_rvalid) begin
                        beat0_q <= mem_rdata;
                        if (cross_q) begin
                            mem_addr <= mem_addr + AW'(NB);
                            state    <= ST_BEAT1;
                        end else begin
                            mem_req   <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_data  <= lane_result;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_BEAT1: begin
                    if (mem_rvalid) begin
                        mem_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= lane_result;
                        state     <= ST_RESP;
                    end
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: 32-bit with and without misaligned
// splitting, and a 64-bit instance, driven from one vector table.
module tb_load_align_unit;
    import load_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel64 = 1'b0;
    logic        a_req_valid = 1'b0;
    logic        w_req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_funct3 = '0;
    logic        mem_rvalid = 1'b0;
    logic [63:0] mem_rdata = '0;

    logic        a_req_ready, a_mem_req, a_rsp_valid, a_rsp_err;
    logic [31:0] a_mem_addr, a_rsp_data;
    logic        n_req_ready, n_mem_req, n_rsp_valid, n_rsp_err;
    logic [31:0] n_mem_addr, n_rsp_data;
    logic        w_req_ready, w_mem_req, w_rsp_valid, w_rsp_err;
    logic [31:0] w_mem_addr;
    logic [63:0] w_rsp_data;

    logic        c_req_ready, c_mem_req, c_rsp_valid, c_rsp_err;
    logic [31:0] c_mem_addr;
    logic [63:0] c_rsp_data;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_align_unit #(.XLEN(32), .AW(32), .ALLOW_MISALIGNED(1)) u_a (
        .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_addr(req_addr), .req_funct3(req_funct3), .mem_req(a_mem_req),
        .mem_addr(a_mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err));

    load_align_unit #(.XLEN(32), .AW(32), .ALLOW_MISALIGNED(0)) u_n (
        .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_ready(n_req_ready),
        .req_addr(req_addr), .req_funct3(req_funct3), .mem_req(n_mem_req),
        .mem_addr(n_mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]),
        .rsp_valid(n_rsp_valid), .rsp_data(n_rsp_data), .rsp_err(n_rsp_err));

    load_align_unit #(.XLEN(64), .AW(32), .ALLOW_MISALIGNED(1)) u_w (
        .clk(clk), .reset(reset), .req_valid(w_req_valid), .req_ready(w_req_ready),
        .req_addr(req_addr), .req_funct3(req_funct3), .mem_req(w_mem_req),
        .mem_addr(w_mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(w_rsp_valid), .rsp_data(w_rsp_data), .rsp_err(w_rsp_err));

    assign c_req_ready = sel64 ? w_req_ready : a_req_ready;
    assign c_mem_req   = sel64 ? w_mem_req   : a_mem_req;
    assign c_mem_addr  = sel64 ? w_mem_addr  : a_mem_addr;
    assign c_rsp_valid = sel64 ? w_rsp_valid : a_rsp_valid;
    assign c_rsp_err   = sel64 ? w_rsp_err   : a_rsp_err;
    assign c_rsp_data  = sel64 ? w_rsp_data  : {32'h0, a_rsp_data};

    typedef struct {
        logic        sel64;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] d0;
        logic [63:0] d1;
        int          waits;
        logic [63:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_beats;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        chk_n;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          cyc, beat, wcnt, n_cyc;
        bit          got, n_mem;
        logic [31:0] n_d;
        logic        n_e;
        string       p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        sel64 = v.sel64;
        #1;
        check({p, " ready_idle"}, 64'(c_req_ready), 64'(1));
        req_addr   = v.addr;
        req_funct3 = v.f3;
        if (v.sel64) w_req_valid = 1'b1;
        else         a_req_valid = 1'b1;
        cyc = 0; beat = 0; wcnt = 0; got = 1'b0; n_cyc = -1; n_mem = 1'b0;
        n_d = '0; n_e = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            a_req_valid = 1'b0;
            w_req_valid = 1'b0;
            mem_rvalid  = 1'b0;
            if (n_rsp_valid && n_cyc < 0) begin
                n_cyc = cyc; n_d = n_rsp_data; n_e = n_rsp_err;
            end
            if (n_mem_req) n_mem = 1'b1;
            if (c_rsp_valid) begin
                got = 1'b1;
                check({p, " latency"}, 64'(cyc), 64'(v.exp_lat));
                check({p, " rsp_data"}, c_rsp_data, v.exp_data);
                check({p, " rsp_err"}, 64'(c_rsp_err), 64'(v.exp_err));
                check({p, " mem_req_in_resp"}, 64'(c_mem_req), 64'(0));
            end else if (c_mem_req) begin
                check({p, " mem_addr"}, 64'(c_mem_addr), 64'(beat == 0 ? v.a0 : v.a1));
                check({p, " ready_busy"}, 64'(c_req_ready), 64'(0));
                if (beat == 0 && wcnt < v.waits) begin
                    wcnt++;
                end else begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = (beat == 0) ? v.d0 : v.d1;
                    beat++;
                end
            end
        end
        check({p, " response_seen"}, 64'(got), 64'(1));
        check({p, " beats"}, 64'(beat), 64'(v.exp_beats));
        @(negedge clk);
        mem_rvalid = 1'b0;
        check({p, " rsp_valid_drop"}, 64'(c_rsp_valid), 64'(0));
        check({p, " rsp_data_hold"}, c_rsp_data, v.exp_data);
        check({p, " ready_after"}, 64'(c_req_ready), 64'(1));
        if (v.chk_n) begin
            check({p, " noalign_latency"}, 64'(n_cyc), 64'(1));
            check({p, " noalign_err"}, 64'(n_e), 64'(1));
            check({p, " noalign_data"}, 64'(n_d), 64'(0));
            check({p, " noalign_mem_req"}, 64'(n_mem), 64'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 32-bit, misaligned splitting enabled
        vecs.push_back('{1'b0, F3_LW,  32'h100, 64'h8899AABB, 64'h0, 0, 64'h8899AABB, 1'b0, 2, 1, 32'h100, 32'h0, 1'b0});
        vecs.push_back('{1'b0, F3_LB,  32'h103, 64'h80123456, 64'h0, 0, 64'hFFFFFF80, 1'b0, 2, 1, 32'h100, 32'h0, 1'b0});
        vecs.push_back('{1'b0, F3_LBU, 32'h103, 64'h80123456, 64'h0, 0, 64'h00000080, 1'b0, 2, 1, 32'h100, 32'h0, 1'b0});
        vecs.push_back('{1'b0, F3_LHU, 32'h102, 64'h80123456, 64'h0, 0, 64'h00008012, 1'b0, 2, 1, 32'h100, 32'h0, 1'b0});
        vecs.push_back('{1'b0, F3_LH,  32'h103, 64'h12345678, 64'h9ABCDEF0, 0, 64'hFFFFF012, 1'b0, 3, 2, 32'h100, 32'h104, 1'b1});
        vecs.push_back('{1'b0, F3_LH,  32'h102, 64'h12345678, 64'h0, 0, 64'h00001234, 1'b0, 2, 1, 32'h100, 32'h0, 1'b0});
        vecs.push_back('{1'b0, F3_LB,  32'h101, 64'h12345678, 64'h0, 0, 64'h00000056, 1'b0, 2, 1, 32'h100, 32'h0, 1'b0});
        vecs.push_back('{1'b0, F3_LW,  32'h102, 64'h12345678, 64'h9ABCDEF0, 0, 64'hDEF01234, 1'b0, 3, 2, 32'h100, 32'h104, 1'b0});
        vecs.push_back('{1'b0, F3_LW,  32'hFFFFFFFE, 64'h11223344, 64'h55667788, 0, 64'h77881122, 1'b0, 3, 2, 32'hFFFFFFFC, 32'h0, 1'b0});
        vecs.push_back('{1'b0, F3_LW,  32'h200, 64'hCAFEF00D, 64'h0, 3, 64'hCAFEF00D, 1'b0, 5, 1, 32'h200, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 3'b111, 32'h100, 64'h0, 64'h0, 0, 64'h0, 1'b1, 1, 0, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, F3_LD,  32'h100, 64'h0, 64'h0, 0, 64'h0, 1'b1, 1, 0, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, F3_LWU, 32'h100, 64'h0, 64'h0, 0, 64'h0, 1'b1, 1, 0, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, F3_LHU, 32'h101, 64'h00FF8000, 64'h0, 0, 64'h0000FF80, 1'b0, 2, 1, 32'h100, 32'h0, 1'b0});
        vecs.push_back('{1'b0, F3_LH,  32'h101, 64'h00FF8000, 64'h0, 0, 64'hFFFFFF80, 1'b0, 2, 1, 32'h100, 32'h0, 1'b0});
        // 64-bit
        vecs.push_back('{1'b1, F3_LD,  32'h8, 64'h0123456789ABCDEF, 64'h0, 0, 64'h0123456789ABCDEF, 1'b0, 2, 1, 32'h8, 32'h0, 1'b0});
        vecs.push_back('{1'b1, F3_LWU, 32'hC, 64'h0123456789ABCDEF, 64'h0, 0, 64'h0000000001234567, 1'b0, 2, 1, 32'h8, 32'h0, 1'b0});
        vecs.push_back('{1'b1, F3_LW,  32'hC, 64'h0123456789ABCDEF, 64'h0, 0, 64'h0000000001234567, 1'b0, 2, 1, 32'h8, 32'h0, 1'b0});
        vecs.push_back('{1'b1, F3_LW,  32'h4, 64'h89ABCDEF00000000, 64'h0, 0, 64'hFFFFFFFF89ABCDEF, 1'b0, 2, 1, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b1, F3_LD,  32'hC, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 0, 64'h7654321001234567, 1'b0, 3, 2, 32'h8, 32'h10, 1'b0});
        vecs.push_back('{1'b1, 3'b111, 32'h8, 64'h0, 64'h0, 0, 64'h0, 1'b1, 1, 0, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b1, F3_LBU, 32'hF, 64'h0123456789ABCDEF, 64'h0, 0, 64'h0000000000000001, 1'b0, 2, 1, 32'h8, 32'h0, 1'b0});
        vecs.push_back('{1'b1, F3_LB,  32'h0, 64'h0123456789ABCDEF, 64'h0, 0, 64'hFFFFFFFFFFFFFFEF, 1'b0, 2, 1, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b1, F3_LH,  32'h7, 64'h8000000000000000, 64'h00000000000000FF, 0, 64'hFFFFFFFFFFFFFF80, 1'b0, 3, 2, 32'h0, 32'h8, 1'b0});

        repeat (3) @(negedge clk);
        check("reset a req_ready", 64'(a_req_ready), 64'(1));
        check("reset a mem_req", 64'(a_mem_req), 64'(0));
        check("reset a mem_addr", 64'(a_mem_addr), 64'(0));
        check("reset a rsp_valid", 64'(a_rsp_valid), 64'(0));
        check("reset a rsp_data", 64'(a_rsp_data), 64'(0));
        check("reset a rsp_err", 64'(a_rsp_err), 64'(0));
        check("reset w req_ready", 64'(w_req_ready), 64'(1));
        check("reset w rsp_data", w_rsp_data, 64'(0));
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // Reset while the second beat of a split load is outstanding.
        @(negedge clk);
        sel64 = 1'b0;
        req_addr = 32'h103; req_funct3 = F3_LH; a_req_valid = 1'b1;
        @(negedge clk);
        a_req_valid = 1'b0;
        check("rst_mid beat0 mem_req", 64'(a_mem_req), 64'(1));
        mem_rvalid = 1'b1; mem_rdata = 64'h12345678;
        @(negedge clk);
        check("rst_mid beat1 mem_addr", 64'(a_mem_addr), 64'(32'h104));
        mem_rdata = 64'h9ABCDEF0;
        reset = 1'b1;
        #1;
        check("rst_mid mem_req", 64'(a_mem_req), 64'(0));
        check("rst_mid req_ready", 64'(a_req_ready), 64'(1));
        check("rst_mid rsp_valid", 64'(a_rsp_valid), 64'(0));
        check("rst_mid mem_addr", 64'(a_mem_addr), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stale_rvalid%0d mem_req", k), 64'(a_mem_req), 64'(0));
            check($sformatf("stale_rvalid%0d rsp_valid", k), 64'(a_rsp_valid), 64'(0));
            check($sformatf("stale_rvalid%0d req_ready", k), 64'(a_req_ready), 64'(1));
        end
        mem_rvalid = 1'b0;
        run_vec('{1'b0, F3_LW, 32'h300, 64'h0BADBEEF, 64'h0, 0, 64'h0BADBEEF, 1'b0, 2, 1, 32'h300, 32'h0, 1'b0}, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
